data_delay_elastic: RTL

DATA_DELAY_ELASTIC -- requirements
Module: data_delay_elastic

---
 rtl/data_delay_elastic.sv | 122 ++++++++++++
 1 files changed

// File: rtl/data_delay_elastic.sv
// Elastic buffer that holds each word for a selectable minimum latency before releasing it.
// Latency: 1..4 cycles from push to out_valid, selected by dly_sel and latched only while the buffer is empty.
// Backpressure: in_ready drops only when all 4 entries are used; a stalled head keeps out_data/out_valid stable.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   dly_sel                  - latency code, L = dly_sel + 1
//   in_data/in_valid/in_ready    - write side handshake
//   out_data/out_valid/out_ready - read side handshake
//   count                    - occupied entries, 0..4
module data_delay_elastic #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       dly_sel,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       count
);

    localparam logic [2:0] FULL    = 3'(DEPTH);
    localparam logic [2:0] AGE_MAX = 3'd4;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [2:0]       age_q [DEPTH];
    logic [2:0]       age_d [DEPTH];
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [2:0]       count_q, count_d;
    logic [2:0]       lat_q, lat_d;
    logic [WIDTH-1:0] last_q, last_d;

    logic             push;
    logic             pop;
    logic [2:0]       lat_sel;
    logic [1:0]       offs;

    assign lat_sel   = {1'b0, dly_sel} + 3'd1;
    assign in_ready  = !rst && (count_q != FULL);
    assign out_valid = (count_q != 3'd0) && (age_q[rd_ptr_q] >= lat_q);
    // Show the head while valid; otherwise keep whatever was shown last.
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : last_q;
    assign count     = count_q;

    always_comb begin
        push     = in_valid && in_ready;
        pop      = out_valid && out_ready;
        mem_d    = mem_q;
        age_d    = age_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        lat_d    = lat_q;
        last_d   = out_data;
        offs     = 2'd0;

        // Age every occupied entry; an entry is occupied when its distance
        // from the read pointer is below the current count.
        for (int i = 0; i < DEPTH; i++) begin
            offs = 2'(i) - rd_ptr_q;
            if (({1'b0, offs} < count_q) && (age_q[i] < AGE_MAX)) begin
                age_d[i] = age_q[i] + 3'd1;
            end
        end

        if (pop) begin
            age_d[rd_ptr_q] = 3'd0;
            rd_ptr_d        = rd_ptr_q + 2'd1;
        end
        // Push after pop: a push never lands on the popped slot because
        // in_ready is low whenever the buffer is full.
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            age_d[wr_ptr_q] = 3'd1;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase

        // Latency is only re-sampled while idle so stored words keep theirs.
        if ((count_q == 3'd0) && !push) begin
            lat_d = lat_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= 3'd0;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            lat_q    <= lat_sel;
            last_q   <= '0;
        end else begin
            age_q    <= age_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            lat_q    <= lat_d;
            last_q   <= last_d;
        end
    end

    // Payload storage needs no reset; ages and count decide what is live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
